// File: rtl/tx_angulo_distancia.sv
// Serializes a latched ASCII angle/distance pair as the frame "aaa,ddd#" into a
// byte-wide UART start/done handshake, one frame per partida pulse.
module tx_angulo_distancia #(
  parameter logic [7:0] SEPARADOR  = 8'h2C,
  parameter logic [7:0] TERMINADOR = 8'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [23:0] angulo,
  input  logic [23:0] distancia,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [7:0]  tx_dado,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    TRANSMITE = 4'd2,
    ESPERA    = 4'd3,
    FINAL     = 4'd4
  } estado_t;

  estado_t     estado_q;
  logic [2:0]  indice_q;
  logic [23:0] angulo_q;
  logic [23:0] distancia_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      indice_q    <= '0;
      angulo_q    <= '0;
      distancia_q <= '0;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (partida) begin
            angulo_q    <= angulo;
            distancia_q <= distancia;
            indice_q    <= '0;
            estado_q    <= PREPARA;
          end
        end
        PREPARA:   estado_q <= TRANSMITE;
        // The UART done pulse is only meaningful once a byte is in flight.
        TRANSMITE: estado_q <= ESPERA;
        ESPERA: begin
          if (tx_pronto) begin
            if (indice_q == 3'd7) begin
              estado_q <= FINAL;
            end else begin
              indice_q <= indice_q + 3'd1;
              estado_q <= TRANSMITE;
            end
          end
        end
        FINAL:     estado_q <= INICIAL;
        default:   estado_q <= INICIAL;
      endcase
    end
  end

  // Byte mux runs off the latched words, so tx_dado is defined even when idle.
  always_comb begin
    tx_dado = 8'h00;
    case (indice_q)
      3'd0: tx_dado = angulo_q[23:16];
      3'd1: tx_dado = angulo_q[15:8];
      3'd2: tx_dado = angulo_q[7:0];
      3'd3: tx_dado = SEPARADOR;
      3'd4: tx_dado = distancia_q[23:16];
      3'd5: tx_dado = distancia_q[15:8];
      3'd6: tx_dado = distancia_q[7:0];
      3'd7: tx_dado = TERMINADOR;
      default: tx_dado = 8'h00;
    endcase
  end

  assign tx_partida = (estado_q == TRANSMITE);
  assign pronto     = (estado_q == FINAL);
  assign ocupado    = (estado_q != INICIAL);
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_tx_angulo_distancia.sv
// Scoreboard bench for tx_angulo_distancia: a background UART responder answers
// each tx_partida after resp_k cycles while a monitor captures emitted bytes.
module tb_tx_angulo_distancia;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic [23:0] angulo = '0;
  logic [23:0] distancia = '0;
  logic        tx_pronto = 1'b0;
  logic        tx_partida;
  logic [7:0]  tx_dado;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  tx_angulo_distancia #(.SEPARADOR(8'h2C), .TERMINADOR(8'h23)) dut (
    .clock      (clock),
    .reset      (reset),
    .partida    (partida),
    .angulo     (angulo),
    .distancia  (distancia),
    .tx_pronto  (tx_pronto),
    .tx_partida (tx_partida),
    .tx_dado    (tx_dado),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  int unsigned n_txp = 0;
  int unsigned n_pronto = 0;
  int unsigned pronto_cyc[$];
  logic [7:0]  obs_q[$];
  int unsigned obs_cyc[$];
  logic [7:0]  exp_q[$];
  int          resp_k = 3;
  int          pend = 0;
  bit          glitch = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Monitor and UART responder share one block so their ordering is fixed.
  always @(negedge clock) begin
    cyc++;
    if (tx_partida) begin
      obs_q.push_back(tx_dado);
      obs_cyc.push_back(cyc);
      n_txp++;
    end
    if (pronto) begin
      n_pronto++;
      pronto_cyc.push_back(cyc);
    end
    tx_pronto = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) tx_pronto = 1'b1;
    end
    if (tx_partida) begin
      pend = resp_k;
      if (glitch) begin
        tx_pronto = 1'b1;
        glitch = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_frame(input logic [23:0] a, input logic [23:0] d);
    exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
    exp_q.push_back(8'h2C);
    exp_q.push_back(d[23:16]); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
    exp_q.push_back(8'h23);
  endtask

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    pronto_cyc.delete();
  endtask

  task automatic wait_pronto(input int unsigned target, input int unsigned budget, output bit ok);
    int unsigned n = 0;
    ok = 1'b1;
    while (n_pronto < target) begin
      if (n >= budget) begin
        ok = 1'b0;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (ocupado !== 1'b0 || db_estado !== 4'd0 || tx_partida !== 1'b0) begin
      n_fail++;
      $display("FAIL in_reset: ocupado=%b db_estado=%0d tx_partida=%b required 0/0/0", ocupado, db_estado, tx_partida);
    end
    tick(); tick();
    reset = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (tx_partida !== 1'b0) begin n_fail++; $display("FAIL idle_tx_partida: got %b required 0", tx_partida); end
    n_checks++;
    if (pronto !== 1'b0) begin n_fail++; $display("FAIL idle_pronto: got %b required 0", pronto); end
    n_checks++;
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL idle_ocupado: got %b required 0", ocupado); end
    n_checks++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL idle_db_estado: got %0d required 0", db_estado); end
    n_checks++;
    if (tx_dado !== 8'h00) begin n_fail++; $display("FAIL idle_tx_dado: got %h required 00", tx_dado); end
    n_checks++;
    if (n_txp !== 0 || n_pronto !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses: tx_partida=%0d pronto=%0d required 0/0", n_txp, n_pronto);
    end
  endtask

  task automatic test_nominal();
    int unsigned start, txp0, pr0;
    bit ok;
    logic [7:0] e, o;
    flush();
    resp_k = 3;
    txp0 = n_txp; pr0 = n_pronto;
    angulo = 24'h313630; distancia = 24'h303435;
    push_frame(24'h313630, 24'h303435);
    partida = 1'b1;
    start = cyc + 1;
    tick();
    partida = 1'b0;
    n_checks++;
    if (ocupado !== 1'b1 || db_estado !== 4'd1) begin
      n_fail++;
      $display("FAIL nominal_prepara: ocupado=%b db_estado=%0d required 1/1", ocupado, db_estado);
    end
    wait_pronto(pr0 + 1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nominal_timeout: pronto count %0d required %0d", n_pronto, pr0 + 1); end
    repeat (10) tick();
    n_checks++;
    if (n_txp - txp0 !== 8) begin n_fail++; $display("FAIL nominal_txp_count: got %0d required 8", n_txp - txp0); end
    n_checks++;
    if (n_pronto - pr0 !== 1) begin n_fail++; $display("FAIL nominal_pronto_count: got %0d required 1", n_pronto - pr0); end
    n_checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] !== start + 2) begin
      n_fail++;
      $display("FAIL nominal_first_latency: got %0d required %0d", (obs_cyc.size() == 0) ? 0 : obs_cyc[0] - start, 2);
    end
    n_checks++;
    if (pronto_cyc.size() == 0 || pronto_cyc[0] !== start + 34) begin
      n_fail++;
      $display("FAIL nominal_pronto_latency: got %0d required 34", (pronto_cyc.size() == 0) ? 0 : pronto_cyc[0] - start);
    end
    n_checks++;
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL nominal_ocupado_after: got %b required 0", ocupado); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL nominal_byte: got %h required %h", o, e); end
    end
  endtask

  task automatic test_latch();
    bit ok;
    int unsigned pr0;
    logic [7:0] e, o;
    flush();
    resp_k = 2;
    pr0 = n_pronto;
    angulo = 24'h303230; distancia = 24'h313939;
    push_frame(24'h303230, 24'h313939);
    partida = 1'b1;
    tick();
    partida = 1'b0;
    angulo = 24'h313430; distancia = 24'h323232;
    wait_pronto(pr0 + 1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL latch_timeout: pronto count %0d required %0d", n_pronto, pr0 + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL latch_byte: got %h required %h", o, e); end
    end
  endtask

  task automatic test_ignored();
    bit ok;
    int unsigned n, txp0, pr0;
    logic [7:0] e, o;
    flush();
    repeat (3) tick();
    resp_k = 3;
    txp0 = n_txp; pr0 = n_pronto;
    angulo = 24'h303435; distancia = 24'h323730;
    push_frame(24'h303435, 24'h323730);
    glitch = 1'b1;
    partida = 1'b1;
    tick();
    partida = 1'b0;
    n = 0;
    while (obs_q.size() < 5 && n < 200) begin tick(); n++; end
    n_checks++;
    if (obs_q.size() < 5) begin n_fail++; $display("FAIL ignored_reach_byte4: got %0d bytes required 5", obs_q.size()); end
    partida = 1'b1;
    tick();
    partida = 1'b0;
    wait_pronto(pr0 + 1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ignored_timeout: pronto count %0d required %0d", n_pronto, pr0 + 1); end
    repeat (40) tick();
    n_checks++;
    if (n_txp - txp0 !== 8) begin n_fail++; $display("FAIL ignored_txp_count: got %0d required 8", n_txp - txp0); end
    n_checks++;
    if (n_pronto - pr0 !== 1) begin n_fail++; $display("FAIL ignored_pronto_count: got %0d required 1", n_pronto - pr0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL ignored_byte: got %h required %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int unsigned n, txp0, pr0;
    logic [7:0] e, o;
    flush();
    resp_k = 3;
    txp0 = n_txp; pr0 = n_pronto;
    angulo = 24'h313830; distancia = 24'h333231;
    push_frame(24'h313830, 24'h333231);
    partida = 1'b1;
    tick();
    partida = 1'b0;
    n = 0;
    while (obs_q.size() < 6 && n < 200) begin tick(); n++; end
    reset = 1'b0;
    #1;
    n_checks++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0 || tx_dado !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_async: db_estado=%0d ocupado=%b tx_dado=%h required 0/0/00", db_estado, ocupado, tx_dado);
    end
    pend = 0;
    tick(); tick();
    reset = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (n_txp - txp0 !== 6 || n_pronto !== pr0) begin
      n_fail++;
      $display("FAIL midreset_aborted: tx_partida=%0d pronto=%0d required 6/0", n_txp - txp0, n_pronto - pr0);
    end
    repeat (6) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_partial_byte: got %h required %h", o, e); end
    end
    flush();
    angulo = 24'h303031; distancia = 24'h393939;
    push_frame(24'h303031, 24'h393939);
    partida = 1'b1;
    tick();
    partida = 1'b0;
    wait_pronto(pr0 + 1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_fresh_timeout: pronto count %0d required %0d", n_pronto, pr0 + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_fresh_byte: got %h required %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int unsigned start, txp0, pr0;
    logic [7:0] e, o;
    flush();
    repeat (3) tick();
    resp_k = 1;
    txp0 = n_txp; pr0 = n_pronto;
    angulo = 24'h323235; distancia = 24'h313030;
    push_frame(24'h323235, 24'h313030);
    push_frame(24'h323235, 24'h313030);
    partida = 1'b1;
    start = cyc + 1;
    wait_pronto(pr0 + 2, 200, ok);
    partida = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: pronto count %0d required %0d", n_pronto, pr0 + 2); end
    repeat (20) tick();
    n_checks++;
    if (n_txp - txp0 !== 16) begin n_fail++; $display("FAIL b2b_txp_count: got %0d required 16", n_txp - txp0); end
    n_checks++;
    if (n_pronto - pr0 !== 2) begin n_fail++; $display("FAIL b2b_pronto_count: got %0d required 2", n_pronto - pr0); end
    n_checks++;
    if (pronto_cyc.size() < 1 || pronto_cyc[0] !== start + 18) begin
      n_fail++;
      $display("FAIL b2b_first_pronto: got %0d required 18", (pronto_cyc.size() < 1) ? 0 : pronto_cyc[0] - start);
    end
    n_checks++;
    if (pronto_cyc.size() < 1 || obs_cyc.size() < 9 || obs_cyc[8] !== pronto_cyc[0] + 3) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d required 3",
               (pronto_cyc.size() < 1 || obs_cyc.size() < 9) ? 0 : obs_cyc[8] - pronto_cyc[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_byte: got %h required %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latch();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_angulo_distancia.md
Name: tx_angulo_distancia

Overview:
- Serializer stage directly downstream of the angle ROM in the Cyclone Cruiser sonar datapath.
- Takes the 24-bit ASCII angle word (three digits, hundreds in bits 23:16) and a 24-bit ASCII distance word, and emits the frame "aaa,ddd#" one byte at a time.
- Feeds the UART transmitter through a start/done byte handshake.
- Runs one frame per `partida` pulse; reports completion with a one-cycle `pronto`.

Parameters:
- SEPARADOR, 8'h2C, byte sent between angle and distance (',').
- TERMINADOR, 8'h23, final byte of the frame ('#').

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- partida  in  1  start request; sampled only in state INICIAL.
- angulo  in  24  ASCII angle {hundreds, tens, units}, e.g. 24'h303230 = "020".
- distancia  in  24  ASCII distance {hundreds, tens, units}.
- tx_pronto  in  1  UART byte-done pulse; honoured only in state ESPERA.
- tx_partida  out  1  one-cycle UART start pulse.
- tx_dado  out  8  byte presented to the UART.
- ocupado  out  1  high from the cycle after `partida` is accepted until `pronto` inclusive.
- pronto  out  1  one-cycle end-of-frame pulse.
- db_estado  out  4  current state code, for debug.

Behaviour:
- States and codes: INICIAL=0, PREPARA=1, TRANSMITE=2, ESPERA=3, FINAL=4. Codes 5..15 are illegal and go to INICIAL on the next edge.
- Reset (reset=0, any time, including mid-frame):
  - State goes to INICIAL immediately (asynchronous).
  - Byte index goes to 0; latched angle and distance registers go to 24'h000000.
  - Outputs: tx_partida=0, pronto=0, ocupado=0, db_estado=0, tx_dado=8'h00.
  - No further UART pulses are issued after a reset.
- INICIAL:
  - If partida=1: latch angulo and distancia, clear the index, go to PREPARA.
  - Otherwise hold. Input changes after the latch edge have no effect on the frame.
- PREPARA: one cycle, then go to TRANSMITE.
- TRANSMITE:
  - tx_partida=1 for exactly this one cycle.
  - tx_dado = byte[index].
  - Next state is ESPERA unconditionally; tx_pronto in this cycle is ignored.
- ESPERA:
  - Hold tx_dado stable.
  - On tx_pronto=1: if index=7 go to FINAL; else increment the index and go to TRANSMITE.
  - With no tx_pronto, wait indefinitely (no timeout).
- FINAL: pronto=1 for one cycle, then go to INICIAL.
- Byte order by index:
  - 0: angulo[23:16]; 1: angulo[15:8]; 2: angulo[7:0]
  - 3: SEPARADOR
  - 4: distancia[23:16]; 5: distancia[15:8]; 6: distancia[7:0]
  - 7: TERMINADOR
- Index is 3 bits and never wraps within a frame; it is cleared on acceptance of `partida`.
- tx_dado is always the mux of the latched registers by index, so it is also defined while idle.
- partida while ocupado=1 is ignored; it is not queued.
- partida held high continuously starts a new frame in the cycle after FINAL returns to INICIAL.
- All outputs are Moore outputs decoded from registered state; there is no combinational path from inputs to outputs.
- Latency, with the UART answering tx_pronto k cycles after each tx_partida:
  - First tx_partida occurs 2 cycles after the partida cycle.
  - pronto occurs 2 + 8(k+1) cycles after the partida cycle.

Test Plan:
- Reset then idle: after reset=0→1 with no partida for 20 cycles → tx_partida=0, pronto=0, ocupado=0, db_estado=0, tx_dado=8'h00.
- Nominal frame: angulo=24'h313630, distancia=24'h303435, UART model answering tx_pronto 3 cycles after each tx_partida → exactly 8 tx_partida pulses, bytes 31,36,30,2C,30,34,35,23 in order; pronto once, 34 cycles after partida; ocupado low afterwards.
- Latch check: angulo=24'h303230 at partida, then angulo changed to 24'h313430 one cycle later → first three bytes are 30,32,30.
- Ignored inputs: partida pulsed during byte 4, and tx_pronto pulsed in the TRANSMITE cycle → frame unaffected, still 8 bytes, no second frame.
- Reset mid-frame: reset=0 while in ESPERA of byte 5 → state 0 and ocupado=0 immediately; no pronto; the next partida sends a full fresh frame starting with index 0.
- Back-to-back: partida held at 1 with a 1-cycle tx_pronto responder → two complete 8-byte frames separated by FINAL→INICIAL→PREPARA; two pronto pulses.
